// File: rtl/uart_rx_sis.sv
// uart_rx_sis: 8N1 receiver on clk_sis, LSB first; define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
// Latency: data_valid rises 9.5*CLKS_PER_BIT+SYNC_STAGES cycles after rx falls (one extra bit time with parity).
// Backpressure: none on the line; a good byte arriving while data_valid is unacknowledged is dropped and flagged by overrun.
module uart_rx_sis #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_sis,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             idx;
    logic [7:0]             shift;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit;
`endif

    // Reset to all ones so a line held low during reset is not taken as a start bit.
    always_ff @(posedge clk_sis) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_sis) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A good-frame delivery in the same cycle overrides this clear.
            if (rd_ack && data_valid) begin
                data_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                            idx   <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_err <= (par_bit != ^shift);
`endif
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            if (!data_valid || rd_ack) begin
                                data_out   <= shift;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Hold here until the line returns high so a stuck-low line yields one error only.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
